brent_kung_pipe: RTL and testbench
==================================

BRENT_KUNG_PIPE -- requirements
Module: brent_kung_pipe

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, as the operand width; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL take parameter CHECK_PARAM, default 1, which when 1 makes elaboration fail for an illegal WIDTH.
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset, with ports clk and rst, both named as above.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in.
REQ-011 sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 cout  output  1  carry out of the MSB.
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  sum is all zeros.

Function
REQ-018 The operation SHALL be add when sub=0: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-019 The operation SHALL be subtract when sub=1: {cout,sum} = a + ~b + (~cin).
- cin=0 gives a-b.
- cin=1 acts as borrow-in and gives a-b-1.
- cout=1 means no borrow.
REQ-020 ovf SHALL be (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the effective B after inversion.
REQ-021 The carry network SHALL be a Brent-Kung parallel-prefix tree of log2(WIDTH) up-sweep levels and log2(WIDTH)-1 down-sweep levels; no ripple chain longer than one bit.
REQ-022 The datapath SHALL be split into 3 register stages:
- S1 registers the per-bit generate/propagate bits (effective cin folded in as bit -1 generate).
- S2 registers the up-sweep group terms.
- S3 registers sum, cout, ovf and zero.
REQ-023 Each stage SHALL carry a valid bit; S3's valid bit drives out_valid.
REQ-024 The global advance signal SHALL be adv = !out_valid || out_ready, and in_ready SHALL equal adv combinationally.
REQ-025 An operand set SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-026 With out_ready held at 1, out_valid SHALL assert exactly 3 clk edges after acceptance, giving a throughput of one result per cycle.
REQ-027 When adv=0, all stage registers and valid bits SHALL hold, and sum/cout/ovf/zero SHALL stay stable while out_valid=1.
REQ-028 Bubbles SHALL propagate with their stage and SHALL NOT be squeezed out.
REQ-029 A result SHALL leave on an edge with out_valid && out_ready; on that same edge S2 SHALL move to S3 and a new input MAY enter S1.
REQ-030 When out_valid=0, sum/cout/ovf/zero SHALL be don't-care, but SHALL hold their last values without toggling.
REQ-031 Operand fields SHALL be sampled only on acceptance; a, b, cin and sub MAY change freely otherwise.

Reset
REQ-032 While rst=1, all stage valid bits SHALL be 0, out_valid SHALL be 0, and sum/cout/ovf/zero SHALL be 0, taking effect immediately without a clock edge.
REQ-033 in_ready SHALL be 1 during and after reset, since out_valid=0.
REQ-034 Reset mid-operation SHALL discard all in-flight results; no partial result SHALL appear after rst deasserts.
REQ-035 The first acceptance after reset SHALL be possible on the first rising edge with rst=0.

Verification
REQ-036 WIDTH=4, out_ready=1, a=2, b=1, cin=1, sub=0 -> 3 edges later: out_valid=1, sum=4, cout=0, ovf=0, zero=0.
REQ-037 WIDTH=4, a=7, b=1, cin=0, sub=0 -> sum=8, cout=0, ovf=1. Then a=15, b=1, cin=0 -> sum=0, cout=1, zero=1, ovf=0.
REQ-038 WIDTH=16, sub=1, cin=0: a=5, b=9 -> sum=0xFFFC, cout=0. Then a=0x8000, b=1 -> sum=0x7FFF, ovf=1, cout=1.
REQ-039 WIDTH=16 streaming test:
- Feed 8 back-to-back operand sets, holding out_ready=0 from the cycle after the first result appears, for 5 cycles.
- Required: in_ready=0 while held.
- Required: first result held stable.
- Required: all 8 results delivered in order with none lost or duplicated.
REQ-040 Reset test: assert rst asynchronously between edges while 3 results are in flight.
- Required: out_valid=0 immediately.
- Required: no stale result after release.
- Required: next accepted operand set produces the correct result 3 edges later.
REQ-041 Exhaustive WIDTH=4 test: every (a, b, cin, sub) combination, 1024 cases, with random out_ready, compared against the behavioural arithmetic model for sum, cout, ovf and zero.

Source files
------------

// File: rtl/brent_kung_pipe.sv
`default_nettype none
// ============================================================================
// Module      : brent_kung_pipe
// Description : Three-stage pipelined WIDTH-bit adder/subtractor built on a
//               Brent-Kung parallel-prefix carry network, with a valid/ready
//               handshake and a single global stall.
//                 S1: per-bit generate/propagate, effective carry-in
//                 S2: up-sweep group generate/propagate terms
//                 S3: down-sweep, sum, cout, ovf, zero
// Ports       : clk       rising-edge clock
//               rst       asynchronous active-high reset
//               in_valid  operand set present
//               in_ready  operand set accepted this cycle (== advance)
//               a, b      operands (WIDTH bits)
//               cin       carry-in (borrow-in when subtracting)
//               sub       0 = add, 1 = subtract
//               out_valid result present
//               out_ready consumer accepts the result
//               sum       result bits
//               cout      carry out of the MSB (1 = no borrow when subtracting)
//               ovf       two's-complement signed overflow
//               zero      sum is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module brent_kung_pipe #(
    parameter int WIDTH       = 16,
    parameter bit CHECK_PARAM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int LOG2W = $clog2(WIDTH);

    generate
        if (CHECK_PARAM && ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0))) begin : g_width_check
            $error("brent_kung_pipe: WIDTH must be a power of two from 4 to 64");
        end
    endgenerate

    // One advance signal stalls every stage together, so bubbles keep their slot.
    logic adv;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // ------------------------------------------------------------------ S1
    // Subtraction is a + ~b + ~cin, so cin doubles as an active-high borrow-in.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;
    logic             s1_amsb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_cin   <= 1'b0;
            s1_amsb  <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_g    <= a & b_eff;
                s1_p    <= a ^ b_eff;
                s1_cin  <= cin_eff;
                s1_amsb <= a[WIDTH-1];
            end
        end
    end

    // ------------------------------------------------------------ up-sweep
    // The carry-in acts as a generate at bit -1; absorbing it into bit 0
    // makes every tree node's group generate include it directly.
    wire [WIDTH-1:0] up_g [0:LOG2W];
    wire [WIDTH-1:0] up_p [0:LOG2W];

    assign up_g[0] = {s1_g[WIDTH-1:1], s1_g[0] | (s1_p[0] & s1_cin)};
    assign up_p[0] = s1_p;

    generate
        for (genvar l = 1; l <= LOG2W; l++) begin : g_up_level
            localparam int SPAN = 1 << (l - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_up_bit
                if (((i + 1) % (2 * SPAN)) == 0) begin : g_node
                    assign up_g[l][i] = up_g[l-1][i] | (up_p[l-1][i] & up_g[l-1][i-SPAN]);
                    assign up_p[l][i] = up_p[l-1][i] & up_p[l-1][i-SPAN];
                end else begin : g_pass
                    assign up_g[l][i] = up_g[l-1][i];
                    assign up_p[l][i] = up_p[l-1][i];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------ S2
    logic             s2_valid;
    logic [WIDTH-1:0] s2_g;     // group generate per tree node
    logic [WIDTH-1:0] s2_gp;    // group propagate per tree node
    logic [WIDTH-1:0] s2_p;     // original per-bit propagate for the sum
    logic             s2_cin;
    logic             s2_amsb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_g     <= '0;
            s2_gp    <= '0;
            s2_p     <= '0;
            s2_cin   <= 1'b0;
            s2_amsb  <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_g    <= up_g[LOG2W];
                s2_gp   <= up_p[LOG2W];
                s2_p    <= s1_p;
                s2_cin  <= s1_cin;
                s2_amsb <= s1_amsb;
            end
        end
    end

    // Only the down-sweep nodes consume group propagate terms.
    logic unused_gp;
    assign unused_gp = ^s2_gp;

    // ---------------------------------------------------------- down-sweep
    // After the up-sweep, nodes at 2^k-1 hold full prefixes; each down level
    // completes the node halfway between two already-complete prefixes.
    wire [WIDTH-1:0] dn_g [0:LOG2W-1];
    assign dn_g[LOG2W-1] = s2_g;

    generate
        for (genvar d = LOG2W - 1; d >= 1; d--) begin : g_down_level
            localparam int SPAN = 1 << (d - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_down_bit
                if ((((i + 1) % (2 * SPAN)) == SPAN) && ((i + 1) > SPAN)) begin : g_node
                    assign dn_g[d-1][i] = dn_g[d][i] | (s2_gp[i] & dn_g[d][i-SPAN]);
                end else begin : g_pass
                    assign dn_g[d-1][i] = dn_g[d][i];
                end
            end
        end
    endgenerate

    // dn_g[0][i] is the carry out of bit i (carry-in included).
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;
    assign carry    = {dn_g[0][WIDTH-2:0], s2_cin};
    assign sum_next = s2_p ^ carry;
    // Operand MSBs agree exactly when the MSB propagate is 0.
    assign ovf_next = !s2_p[WIDTH-1] && (sum_next[WIDTH-1] != s2_amsb);

    // ------------------------------------------------------------------ S3
    // Result registers load only with a valid result so they hold their last
    // value (without toggling) while bubbles pass through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                sum  <= sum_next;
                cout <= dn_g[0][WIDTH-1];
                ovf  <= ovf_next;
                zero <= (sum_next == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_brent_kung_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_brent_kung_pipe
// Description : Self-checking bench driving a WIDTH=4 and a WIDTH=16 instance
//               with the same handshake and operands (the 4-bit instance sees
//               the low operand bits) and comparing both against an
//               arithmetic reference model and a three-slot pipeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brent_kung_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;

    logic        rdy4, ov4, cout4, ovf4, zero4;
    logic [3:0]  sum4;
    logic        rdy16, ov16, cout16, ovf16, zero16;
    logic [15:0] sum16;

    always #5 clk = ~clk;

    brent_kung_pipe #(.WIDTH(4), .CHECK_PARAM(1'b1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .out_valid(ov4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    brent_kung_pipe #(.WIDTH(16), .CHECK_PARAM(1'b1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        zero;
        logic        ovf;
        logic        cout;
        logic [15:0] sum;
    } res_t;

    // Plain integer arithmetic: unsigned sum for sum/cout, signed result
    // range for overflow.
    function automatic res_t ref_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                                    input logic c, input logic s);
        res_t              r;
        longint unsigned   mask, ua, ub, full;
        longint            half, sa, sb, sres;
        mask = (64'd1 << w) - 64'd1;
        half = 64'sd1 << (w - 1);
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = (ua >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (ub >= half) ? longint'(ub) - 2 * half : longint'(ub);
        if (!s) begin
            full = ua + ub + longint'(c);
            sres = sa + sb + longint'(c);
        end else begin
            full = ua + (~ub & mask) + (c ? 64'd0 : 64'd1);
            sres = sa - sb - longint'(c);
        end
        r.sum  = 16'(full & mask);
        r.cout = ((full >> w) & 64'd1) != 0;
        r.ovf  = (sres > half - 1) || (sres < -half);
        r.zero = ((full & mask) == 0);
        return r;
    endfunction

    // Pipeline model: three slots, all advancing together when the last
    // slot is empty or its result is being taken.
    bit   mv [3];
    res_t m4 [3];
    res_t m16[3];
    res_t last4, last16;
    bit   accepted;
    int   delivered;

    task automatic model_clear();
        for (int k = 0; k < 3; k++) mv[k] = 1'b0;
        last4  = '0;
        last16 = '0;
    endtask

    task automatic cycle();
        res_t e4, e16;
        bit   adv_m;
        @(negedge clk);
        adv_m = !mv[2] || out_ready;
        check("in_ready4",  rdy4,  adv_m);
        check("in_ready16", rdy16, adv_m);
        check("out_valid4", ov4,   mv[2]);
        check("out_valid16", ov16, mv[2]);
        e4  = mv[2] ? m4[2]  : last4;
        e16 = mv[2] ? m16[2] : last16;
        check("sum4",    sum4,  e4.sum[3:0]);
        check("flags4",  {cout4, ovf4, zero4},    {e4.cout, e4.ovf, e4.zero});
        check("sum16",   sum16, e16.sum);
        check("flags16", {cout16, ovf16, zero16}, {e16.cout, e16.ovf, e16.zero});
        if (mv[2]) begin
            last4  = m4[2];
            last16 = m16[2];
        end
        if (ov16 && out_ready) delivered++;
        accepted = 1'b0;
        if (adv_m) begin
            mv[2] = mv[1]; m4[2] = m4[1]; m16[2] = m16[1];
            mv[1] = mv[0]; m4[1] = m4[0]; m16[1] = m16[0];
            mv[0] = in_valid;
            if (in_valid) begin
                m4[0]  = ref_op(4,  a, b, cin, sub);
                m16[0] = ref_op(16, a, b, cin, sub);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic c,
                         input logic s, input bit rand_ready);
        a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 50 && !accepted; n++) begin
            if (rand_ready) out_ready = 1'($urandom);
            cycle();
        end
        if (!accepted) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, {ov4, ov16}, 2'b00);
        check({tag, "_in_ready"},  {rdy4, rdy16}, 2'b11);
        check({tag, "_sum4"},      sum4, 4'h0);
        check({tag, "_sum16"},     sum16, 16'h0);
        check({tag, "_flags"},     {cout4, ovf4, zero4, cout16, ovf16, zero16}, 6'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t       r;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          sent, hold_left;
        bit          seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        delivered = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // First edge after reset accepts; result visible after the third edge.
        issue(16'd2, 16'd1, 1'b1, 1'b0, 1'b0);
        cycle();
        check("lat_not_yet", ov4, 1'b0);
        cycle();
        check("lat3_valid", ov4, 1'b1);
        check("lat3_sum",   sum4, 4'd4);
        check("lat3_flags", {cout4, ovf4, zero4}, 3'b000);

        // Signed overflow, then wrap to zero with carry out (4-bit).
        issue(16'd7, 16'd1, 1'b0, 1'b0, 1'b0);
        issue(16'd15, 16'd1, 1'b0, 1'b0, 1'b0);
        cycle();
        check("w4_ovf_sum",   sum4, 4'd8);
        check("w4_ovf_flags", {cout4, ovf4}, 2'b01);
        cycle();
        check("w4_wrap_sum",   sum4, 4'd0);
        check("w4_wrap_flags", {cout4, ovf4, zero4}, 3'b101);

        // Subtraction with borrow, then signed overflow on subtract (16-bit).
        issue(16'd5, 16'd9, 1'b0, 1'b1, 1'b0);
        issue(16'h8000, 16'd1, 1'b0, 1'b1, 1'b0);
        cycle();
        check("w16_sub_sum",  sum16, 16'hFFFC);
        check("w16_sub_cout", cout16, 1'b0);
        cycle();
        check("w16_subovf_sum",   sum16, 16'h7FFF);
        check("w16_subovf_flags", {cout16, ovf16}, 2'b11);
        repeat (3) cycle();

        // Streaming: 8 back-to-back sets, 5-cycle stall after first result.
        delivered = 0; sent = 0; hold_left = 0; seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid = (sent < 8);
            if (seen && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
                #1;
                check("stream_hold_ready", {rdy4, rdy16}, 2'b00);
            end else begin
                out_ready = 1'b1;
            end
            cycle();
            if (accepted) sent++;
            if (!seen && ov16) begin
                seen = 1'b1;
                hold_left = 5;
            end
        end
        in_valid = 1'b0;
        check("stream_sent", sent, 8);
        check("stream_delivered", delivered, 8);

        // Asynchronous reset with three results in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) cycle();
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        issue(ra, rb, rc, rs, 1'b0);
        cycle();
        cycle();
        r = ref_op(16, ra, rb, rc, rs);
        check("rst_recover_valid", ov16, 1'b1);
        check("rst_recover_sum",   sum16, r.sum);
        check("rst_recover_flags", {cout16, ovf16, zero16}, {r.cout, r.ovf, r.zero});

        // Every 4-bit (a, b, cin, sub) combination with random backpressure
        // and bubbles; upper operand bits randomised for the 16-bit instance.
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] iv;
            iv = 10'(i);
            if (($urandom % 4) == 0) begin
                out_ready = 1'($urandom);
                cycle();
            end
            issue({12'($urandom), iv[3:0]}, {12'($urandom), iv[7:4]}, iv[8], iv[9], 1'b1);
        end
        out_ready = 1'b1;
        repeat (5) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
